// File: rtl/trap_if.sv
// Trap controller bus: stage exception requests, CSR access port,
// pipeline flush and PC redirect handshake.
interface trap_if;
    logic [2:0]  req_valid;
    logic [14:0] req_cause;
    logic [95:0] req_pc;
    logic [95:0] req_tval;
    logic        mret_valid;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;
    logic        trap_taken;

    modport master (
        output req_valid, req_cause, req_pc, req_tval, mret_valid,
        output csr_we, csr_addr, csr_wdata, redirect_ready,
        input  csr_rdata, flush, redirect_valid, redirect_pc,
        input  busy, trap_taken
    );

    modport slave (
        input  req_valid, req_cause, req_pc, req_tval, mret_valid,
        input  csr_we, csr_addr, csr_wdata, redirect_ready,
        output csr_rdata, flush, redirect_valid, redirect_pc,
        output busy, trap_taken
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap entry/exit sequencer and owner of mtvec, mepc,
// mcause and mtval (direct mode only).
module trap_controller #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0004
) (
    input logic   clk,
    input logic   rst,
    trap_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, FLUSH, WRITE, REDIRECT, MRET_FLUSH, MRET_REDIRECT
    } state_e;

    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

    state_e          state_q, state_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [4:0]      cap_cause_q, cap_cause_d;
    logic [XLEN-1:0] cap_pc_q, cap_pc_d;
    logic [XLEN-1:0] cap_tval_q, cap_tval_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    logic [4:0]      sel_cause;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] sel_tval;

    // Oldest stage (memory) has priority over decode and fetch.
    always_comb begin
        sel_cause = '0;
        sel_pc    = '0;
        sel_tval  = '0;
        priority case (1'b1)
            bus.req_valid[2]: begin
                sel_cause = bus.req_cause[14:10];
                sel_pc    = bus.req_pc[2*XLEN +: XLEN];
                sel_tval  = bus.req_tval[2*XLEN +: XLEN];
            end
            bus.req_valid[1]: begin
                sel_cause = bus.req_cause[9:5];
                sel_pc    = bus.req_pc[XLEN +: XLEN];
                sel_tval  = bus.req_tval[XLEN +: XLEN];
            end
            bus.req_valid[0]: begin
                sel_cause = bus.req_cause[4:0];
                sel_pc    = bus.req_pc[0 +: XLEN];
                sel_tval  = bus.req_tval[0 +: XLEN];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cap_cause_d = cap_cause_q;
        cap_pc_d    = cap_pc_q;
        cap_tval_d  = cap_tval_q;
        rpc_d       = rpc_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_d     = FLUSH;
                    cap_cause_d = sel_cause;
                    cap_pc_d    = sel_pc & ALIGN;
                    cap_tval_d  = sel_tval;
                end else if (bus.mret_valid) begin
                    state_d = MRET_FLUSH;
                end
            end
            FLUSH: state_d = WRITE;
            WRITE: begin
                state_d = REDIRECT;
                rpc_d   = mtvec_q;
            end
            REDIRECT: begin
                if (bus.redirect_ready) state_d = IDLE;
            end
            MRET_FLUSH: begin
                state_d = MRET_REDIRECT;
                rpc_d   = mepc_q;
            end
            MRET_REDIRECT: begin
                if (bus.redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Trap update overrides a same-cycle software write.
    always_comb begin
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        if (bus.csr_we) begin
            unique case (bus.csr_addr)
                12'h305: mtvec_d  = bus.csr_wdata & ALIGN;
                12'h341: mepc_d   = bus.csr_wdata & ALIGN;
                12'h342: mcause_d = bus.csr_wdata;
                12'h343: mtval_d  = bus.csr_wdata;
                default: ;
            endcase
        end
        if (state_q == WRITE) begin
            mepc_d   = cap_pc_q;
            mcause_d = {{(XLEN-5){1'b0}}, cap_cause_q};
            mtval_d  = cap_tval_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mtvec_q     <= MTVEC_RST;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            cap_cause_q <= '0;
            cap_pc_q    <= '0;
            cap_tval_q  <= '0;
            rpc_q       <= '0;
        end else begin
            state_q     <= state_d;
            mtvec_q     <= mtvec_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            cap_cause_q <= cap_cause_d;
            cap_pc_q    <= cap_pc_d;
            cap_tval_q  <= cap_tval_d;
            rpc_q       <= rpc_d;
        end
    end

    always_comb begin
        bus.csr_rdata = '0;
        unique case (bus.csr_addr)
            12'h305: bus.csr_rdata = mtvec_q;
            12'h341: bus.csr_rdata = mepc_q;
            12'h342: bus.csr_rdata = mcause_q;
            12'h343: bus.csr_rdata = mtval_q;
            default: ;
        endcase
    end

    assign bus.flush          = (state_q == FLUSH) || (state_q == MRET_FLUSH);
    assign bus.redirect_valid = (state_q == REDIRECT) || (state_q == MRET_REDIRECT);
    assign bus.redirect_pc    = rpc_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.trap_taken     = (state_q == REDIRECT) && bus.redirect_ready;
endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: directed cases plus a random
// mix of traps, mrets and CSR writes against a behavioural model.
module tb_trap_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;

    trap_if bus ();

    trap_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        trap;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_mtvec  = 32'h4;
        m_mepc   = 32'h0;
        m_mcause = 32'h0;
        m_mtval  = 32'h0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
        bus.csr_addr = a;
        #1;
        chk(nm, bus.csr_rdata, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 50) begin
            cyc();
            n++;
        end
        if (bus.busy) chk("idle_timeout", {31'b0, bus.busy}, 32'h0);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        bus.csr_we    = 1'b1;
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        cyc();
        bus.csr_we = 1'b0;
        case (a)
            12'h305: m_mtvec  = {d[31:2], 2'b00};
            12'h341: m_mepc   = {d[31:2], 2'b00};
            12'h342: m_mcause = d;
            12'h343: m_mtval  = d;
            default: ;
        endcase
    endtask

    // wmode 1: sw write to mcause in WRITE; 2: sw write to mtvec in REDIRECT
    task automatic do_trap(input logic [2:0] v, input logic [14:0] c,
                           input logic [95:0] pc, input logic [95:0] tv,
                           input int delay, input logic with_mret, input int wmode);
        int w;
        logic [31:0] exp_pc;
        logic [31:0] nv;
        wait_idle();
        w = 2;
        while (w > 0 && !v[w]) w--;
        exp_pc   = m_mtvec;
        m_mepc   = pc[32*w +: 32] & 32'hFFFF_FFFC;
        m_mcause = {27'b0, c[5*w +: 5]};
        m_mtval  = tv[32*w +: 32];
        q.push_back('{exp_pc, 1'b1});
        bus.redirect_ready = 1'b0;
        bus.req_valid  = v;
        bus.req_cause  = c;
        bus.req_pc     = pc;
        bus.req_tval   = tv;
        bus.mret_valid = with_mret;
        cyc();
        bus.req_valid  = 3'b0;
        bus.mret_valid = 1'b0;
        chk("flush_n1", {31'b0, bus.flush}, 32'h1);
        chk("rv_n1", {31'b0, bus.redirect_valid}, 32'h0);
        cyc();
        chk("flush_n2", {31'b0, bus.flush}, 32'h0);
        if (wmode == 1) begin
            bus.csr_we    = 1'b1;
            bus.csr_addr  = 12'h342;
            bus.csr_wdata = 32'hFF;
        end
        cyc();
        bus.csr_we = 1'b0;
        chk("rv_n3", {31'b0, bus.redirect_valid}, 32'h1);
        rd(12'h341, m_mepc, "mepc");
        rd(12'h342, m_mcause, "mcause");
        rd(12'h343, m_mtval, "mtval");
        for (int i = 0; i < delay; i++) begin
            chk("rv_hold", {31'b0, bus.redirect_valid}, 32'h1);
            chk("rpc_hold", bus.redirect_pc, exp_pc);
            chk("tt_low", {31'b0, bus.trap_taken}, 32'h0);
            if (wmode == 2 && i == 0) begin
                nv = $urandom;
                bus.csr_we    = 1'b1;
                bus.csr_addr  = 12'h305;
                bus.csr_wdata = nv;
                m_mtvec = {nv[31:2], 2'b00};
            end
            cyc();
            bus.csr_we = 1'b0;
        end
        if (wmode == 2) rd(12'h305, m_mtvec, "mtvec_in_redirect");
        bus.redirect_ready = 1'b1;
        cyc();
        bus.redirect_ready = 1'b0;
        chk("busy_done", {31'b0, bus.busy}, 32'h0);
        chk("tt_after", {31'b0, bus.trap_taken}, 32'h0);
    endtask

    task automatic do_mret();
        wait_idle();
        q.push_back('{m_mepc, 1'b0});
        bus.mret_valid = 1'b1;
        cyc();
        bus.mret_valid = 1'b0;
        chk("mret_flush", {31'b0, bus.flush}, 32'h1);
        cyc();
        chk("mret_flush_end", {31'b0, bus.flush}, 32'h0);
        chk("mret_rv", {31'b0, bus.redirect_valid}, 32'h1);
        bus.redirect_ready = 1'b1;
        cyc();
        bus.redirect_ready = 1'b0;
        chk("mret_busy", {31'b0, bus.busy}, 32'h0);
    endtask

    // Scoreboard monitor: every redirect handshake consumes one expectation
    always @(negedge clk) begin
        if (!rst && bus.redirect_valid && bus.redirect_ready) begin
            chk("redir_expected", {31'b0, q.size() != 0}, 32'h1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("redirect_pc", bus.redirect_pc, e.pc);
                chk("trap_taken", {31'b0, bus.trap_taken}, {31'b0, e.trap});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  v;
        logic [14:0] c;
        logic [95:0] pc, tv;
        logic [11:0] addrs [5];
        int kind;
        addrs[0] = 12'h305; addrs[1] = 12'h341; addrs[2] = 12'h342;
        addrs[3] = 12'h343; addrs[4] = 12'h300;
        bus.req_valid = '0; bus.req_cause = '0; bus.req_pc = '0;
        bus.req_tval = '0; bus.mret_valid = 1'b0; bus.csr_we = 1'b0;
        bus.csr_addr = '0; bus.csr_wdata = '0; bus.redirect_ready = 1'b0;
        model_reset();
        repeat (3) cyc();
        chk("rst_flush", {31'b0, bus.flush}, 32'h0);
        chk("rst_rv", {31'b0, bus.redirect_valid}, 32'h0);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_rpc", bus.redirect_pc, 32'h0);
        rd(12'h305, 32'h4, "rst_mtvec");
        rd(12'h341, 32'h0, "rst_mepc");
        @(negedge clk) rst = 1'b0;
        cyc();

        do_trap(3'b001, 15'd0, {64'h0, 32'h100}, {64'h0, 32'h102}, 0, 1'b0, 0);
        do_trap(3'b111, {5'd4, 5'd2, 5'd0}, {32'h208, 32'h204, 32'h200},
                {32'hA, 32'hB, 32'hC}, 0, 1'b0, 0);
        csr_write(12'h305, 32'h2003);
        rd(12'h305, 32'h2000, "mtvec_wr");
        do_trap(3'b010, {5'd0, 5'd3, 5'd0}, {32'h0, 32'h344, 32'h0},
                {32'h0, 32'h55, 32'h0}, 5, 1'b0, 0);
        do_trap(3'b100, {5'd7, 5'd0, 5'd0}, {32'h40C, 64'h0},
                {32'h77, 64'h0}, 1, 1'b1, 0);
        do_mret();
        do_trap(3'b001, 15'd5, {64'h0, 32'h500}, {64'h0, 32'h9}, 0, 1'b0, 1);
        rd(12'h342, 32'h5, "mcause_wins");
        rd(12'h300, 32'h0, "unowned");
        do_trap(3'b010, {5'd0, 5'd6, 5'd0}, {32'h0, 32'h600, 32'h0},
                {32'h0, 32'h1, 32'h0}, 2, 1'b0, 2);

        wait_idle();
        bus.req_valid = 3'b001; bus.req_cause = 15'd1;
        bus.req_pc = 96'h700; bus.req_tval = 96'h0;
        cyc();
        bus.req_valid = 3'b0;
        cyc(); cyc();
        chk("pre_rst_rv", {31'b0, bus.redirect_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_rv", {31'b0, bus.redirect_valid}, 32'h0);
        chk("arst_busy", {31'b0, bus.busy}, 32'h0);
        chk("arst_rpc", bus.redirect_pc, 32'h0);
        rd(12'h305, 32'h4, "arst_mtvec");
        rd(12'h341, 32'h0, "arst_mepc");
        @(negedge clk) rst = 1'b0;
        cyc();
        do_trap(3'b001, 15'd2, {64'h0, 32'h800}, {64'h0, 32'h3}, 0, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                csr_write(addrs[$urandom_range(0, 4)], $urandom);
            end else if (kind == 3) begin
                do_mret();
            end else begin
                v  = 3'($urandom_range(1, 7));
                c  = 15'($urandom);
                pc = {$urandom, $urandom, $urandom};
                tv = {$urandom, $urandom, $urandom};
                do_trap(v, c, pc, tv, $urandom_range(0, 3), 1'($urandom), 0);
            end
            rd(12'h305, m_mtvec, "r_mtvec");
            rd(12'h341, m_mepc, "r_mepc");
        end
        cyc(); cyc();
        chk("queue_drained", q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
